// File: rtl/clock_pkg.sv
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared state encoding and default parameters for the
//                clock supervisor and its clock-enable dividers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    localparam int unsigned c_STATE_W = 2;

    localparam logic [c_STATE_W-1:0] c_ST_WAIT_LOCK = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_HOLD      = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_RUN       = 2'd2;

    localparam int unsigned c_DEF_N_CH        = 4;
    localparam int unsigned c_DEF_CNT_W       = 16;
    localparam int unsigned c_DEF_LOCK_CYCLES = 1024;
    localparam int unsigned c_DEF_RST_HOLD    = 16;
    localparam int unsigned c_DEF_DIV_RESET   = 1;
    localparam int unsigned c_DEF_LOSS_W      = 8;

endpackage

`default_nettype wire

// File: rtl/ce_divider.sv
// ============================================================================
//  Module      : ce_divider
//  Description : One clock-enable channel: shadow/active divisor, period
//                counter and registered one-cycle enable pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ce_divider
    import clock_pkg::*;
#(
    parameter int unsigned CNT_W     = c_DEF_CNT_W,
    parameter int unsigned DIV_RESET = c_DEF_DIV_RESET
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_div,
    input  logic             i_div_load,
    output logic             o_ce
);

    logic [CNT_W-1:0] r_shadow;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ce;

    logic [CNT_W-1:0] w_shadow_next;
    logic [CNT_W-1:0] w_div_raw;
    logic [CNT_W-1:0] w_div_now;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_hit;

    // The edge closing a pulse starts a new period, so it already uses the
    // divisor being adopted (including a load arriving in that same cycle).
    always_comb begin
        w_shadow_next = i_div_load ? i_div : r_shadow;
        w_div_raw     = r_ce ? w_shadow_next : r_active;
        w_div_now     = (w_div_raw == '0) ? CNT_W'(1) : w_div_raw;
        w_cnt_inc     = r_cnt + CNT_W'(1);
        w_hit         = (w_cnt_inc == w_div_now);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shadow <= CNT_W'(DIV_RESET);
            r_active <= CNT_W'(DIV_RESET);
            r_cnt    <= '0;
            r_ce     <= 1'b0;
        end else begin
            r_shadow <= w_shadow_next;
            if (!i_run) begin
                r_cnt    <= '0;
                r_ce     <= 1'b0;
                r_active <= r_shadow;
            end else begin
                r_ce  <= w_hit;
                r_cnt <= w_hit ? '0 : w_cnt_inc;
                if (r_ce) begin
                    r_active <= w_shadow_next;
                end
            end
        end
    end

    assign o_ce = r_ce;

endmodule

`default_nettype wire

// File: rtl/clock_supervisor.sv
// ============================================================================
//  Module      : clock_supervisor
//  Description : PLL lock qualification, sequenced system reset release and
//                N_CH programmable clock-enable strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_supervisor
    import clock_pkg::*;
#(
    parameter int unsigned N_CH        = c_DEF_N_CH,
    parameter int unsigned CNT_W       = c_DEF_CNT_W,
    parameter int unsigned LOCK_CYCLES = c_DEF_LOCK_CYCLES,
    parameter int unsigned RST_HOLD    = c_DEF_RST_HOLD,
    parameter int unsigned DIV_RESET   = c_DEF_DIV_RESET,
    parameter int unsigned LOSS_W      = c_DEF_LOSS_W
) (
    input  logic                  i_sys_clk,
    input  logic                  i_rst,
    input  logic                  i_pll_lock,
    input  logic [N_CH*CNT_W-1:0] i_div,
    input  logic                  i_div_load,
    output logic                  o_sys_rst,
    output logic [N_CH-1:0]       o_ce,
    output logic                  o_locked,
    output logic [LOSS_W-1:0]     o_lock_loss_cnt
);

    localparam int unsigned c_LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int unsigned c_HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [c_LOCK_W-1:0] c_LOCK_LAST = c_LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RST_HOLD - 1);

    logic                 r_sync_meta;
    logic                 r_lock_s;
    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;
    logic [c_LOCK_W-1:0]  r_lock_cnt;
    logic [c_LOCK_W-1:0]  w_lock_cnt_next;
    logic [c_HOLD_W-1:0]  r_hold_cnt;
    logic [c_HOLD_W-1:0]  w_hold_cnt_next;
    logic                 w_loss_inc;
    logic                 w_run_next;
    logic                 r_sys_rst;
    logic                 r_locked;
    logic [LOSS_W-1:0]    r_loss_cnt;

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_sync_meta <= i_pll_lock;
            r_lock_s    <= r_sync_meta;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_lock_cnt_next = '0;
        w_hold_cnt_next = '0;
        w_loss_inc      = 1'b0;
        case (r_state)
            c_ST_WAIT_LOCK: begin
                if (r_lock_s) begin
                    if (r_lock_cnt == c_LOCK_LAST) begin
                        w_state_next = c_ST_HOLD;
                    end else begin
                        w_lock_cnt_next = r_lock_cnt + c_LOCK_W'(1);
                    end
                end
            end
            c_ST_HOLD: begin
                if (!r_lock_s) begin
                    w_state_next = c_ST_WAIT_LOCK;
                end else if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_next = c_ST_RUN;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + c_HOLD_W'(1);
                end
            end
            c_ST_RUN: begin
                if (!r_lock_s) begin
                    w_state_next = c_ST_WAIT_LOCK;
                    w_loss_inc   = 1'b1;
                end
            end
            default: w_state_next = c_ST_WAIT_LOCK;
        endcase
    end

    assign w_run_next = (w_state_next == c_ST_RUN);

    // Reset and lock outputs follow the next state so they change on the
    // same edge as the state transition itself.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= c_ST_WAIT_LOCK;
            r_lock_cnt <= '0;
            r_hold_cnt <= '0;
            r_sys_rst  <= 1'b1;
            r_locked   <= 1'b0;
            r_loss_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_lock_cnt <= w_lock_cnt_next;
            r_hold_cnt <= w_hold_cnt_next;
            r_sys_rst  <= ~w_run_next;
            r_locked   <= w_run_next;
            if (w_loss_inc && (r_loss_cnt != '1)) begin
                r_loss_cnt <= r_loss_cnt + LOSS_W'(1);
            end
        end
    end

    assign o_sys_rst       = r_sys_rst;
    assign o_locked        = r_locked;
    assign o_lock_loss_cnt = r_loss_cnt;

    generate
        for (genvar k = 0; k < int'(N_CH); k++) begin : g_ch
            ce_divider #(
                .CNT_W     (CNT_W),
                .DIV_RESET (DIV_RESET)
            ) u_ce_divider (
                .i_clk      (i_sys_clk),
                .i_rst      (i_rst),
                .i_run      (w_run_next),
                .i_div      (i_div[k*CNT_W +: CNT_W]),
                .i_div_load (i_div_load),
                .o_ce       (o_ce[k])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clock_supervisor.sv
// ============================================================================
//  Module      : tb_clock_supervisor
//  Description : Directed self-checking bench for clock_supervisor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_supervisor;

    localparam int unsigned N_CH        = 4;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned LOCK_CYCLES = 8;
    localparam int unsigned RST_HOLD    = 4;
    localparam int unsigned DIV_RESET   = 1;
    localparam int unsigned LOSS_W      = 8;

    logic                  clk  = 1'b0;
    logic                  rst  = 1'b1;
    logic                  lock = 1'b0;
    logic                  load = 1'b0;
    logic [N_CH*CNT_W-1:0] div  = '0;
    logic                  sys_rst;
    logic [N_CH-1:0]       ce;
    logic                  locked;
    logic [LOSS_W-1:0]     loss_cnt;

    int checks = 0;
    int errors = 0;

    clock_supervisor #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .LOCK_CYCLES (LOCK_CYCLES),
        .RST_HOLD    (RST_HOLD),
        .DIV_RESET   (DIV_RESET),
        .LOSS_W      (LOSS_W)
    ) dut (
        .i_sys_clk       (clk),
        .i_rst           (rst),
        .i_pll_lock      (lock),
        .i_div           (div),
        .i_div_load      (load),
        .o_sys_rst       (sys_rst),
        .o_ce            (ce),
        .o_locked        (locked),
        .o_lock_loss_cnt (loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts edges until o_sys_rst drops, bounded.
    task automatic wait_run(input string tag, input int exp_edges);
        int n = 0;
        while (sys_rst !== 1'b0 && n < 60) begin
            step(1);
            n++;
        end
        chk(tag, n, exp_edges);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e;
        int n;

        // Reset state
        rst  = 1'b1;
        lock = 1'b1;
        step(3);
        chk("rst_sys_rst", sys_rst, 1);
        chk("rst_locked", locked, 0);
        chk("rst_ce", ce, 0);
        chk("rst_loss", loss_cnt, 0);

        // Release reset (edge 0); load {ch3=0, ch2=3, ch1=2, ch0=1} on edge 1
        rst  = 1'b0;
        div  = {16'd0, 16'd3, 16'd2, 16'd1};
        load = 1'b1;
        step(1);
        load = 1'b0;
        wait_run("first_run_edge", 13);
        chk("locked_rises", locked, 1);

        // Enable pattern across RUN cycles 1..6
        for (int c = 1; c <= 6; c++) begin
            e = {1'b1, (c % 3 == 0), (c % 2 == 0), 1'b1};
            chk("ce_pattern", ce, e);
            step(1);
        end

        // ch1 -> 4, then 6 loaded mid-period
        div  = {16'd0, 16'd3, 16'd4, 16'd1};
        load = 1'b1;
        step(1);
        load = 1'b0;
        n = 0;
        while (ce[1] !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        chk("ch1_pulse_found", (n < 20), 1);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk("ch1_div4", ce[1], (k == 4));
        end
        step(2);
        div  = {16'd0, 16'd3, 16'd6, 16'd1};
        load = 1'b1;
        step(1);
        load = 1'b0;
        for (int k = 4; k <= 16; k++) begin
            step(1);
            chk("ch1_4to6", ce[1], (k == 4 || k == 10 || k == 16));
        end

        // Lock loss in RUN
        lock = 1'b0;
        step(2);
        chk("loss_edge2_rst", sys_rst, 0);
        step(1);
        chk("loss_edge3_rst", sys_rst, 1);
        chk("loss_ce", ce, 0);
        chk("loss_locked", locked, 0);
        chk("loss_cnt1", loss_cnt, 1);
        step(2);

        // Glitch in WAIT_LOCK after 5 high samples
        lock = 1'b1;
        step(5);
        lock = 1'b0;
        step(2);
        lock = 1'b1;
        wait_run("glitch_restart", 14);
        chk("glitch_locked", locked, 1);

        // Saturation of the loss counter
        for (int i = 0; i < 300; i++) begin
            lock = 1'b0;
            step(4);
            lock = 1'b1;
            step(15);
            if (i == 252) chk("loss_cnt254", loss_cnt, 254);
        end
        chk("loss_sat", loss_cnt, 255);
        chk("sat_running", sys_rst, 0);

        // Async reset mid-RUN with non-default divisors
        div  = {16'd2, 16'd3, 16'd5, 16'd1};
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(12);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_sys_rst", sys_rst, 1);
        chk("arst_ce", ce, 0);
        chk("arst_locked", locked, 0);
        chk("arst_loss", loss_cnt, 0);
        step(2);
        rst = 1'b0;
        wait_run("arst_rerun", 14);
        for (int c = 0; c < 3; c++) begin
            chk("arst_div_default", ce, 4'hF);
            step(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
